muldiv_unit: RTL

Parametrised iterative multiply/divide unit for the EX stage. It replaces the separate multiplier and divider instances with a single `start`/`busy`/`done` engine. It executes MULT, MULTU, DIV and DIVU on `WIDTH`-bit operands and produces a `{hi, lo}` result pair. It drives a stall request that EX forwards into the pipeline stall bus, and it accepts an annul from pipeline flush.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
//  Module  : muldiv_pkg
//  Purpose : Shared encodings and helpers for the iterative mul/div engine.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Widest vector the negate helper handles; callers zero-extend and truncate.
  localparam int unsigned NEG_W = 128;

  function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] x);
    return ~x + NEG_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module  : muldiv_unit
//  Purpose : Iterative MULT/MULTU/DIV/DIVU engine with start/busy/done and
//            pipeline stall request. WIDTH from 4 up to 64.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             annul,
  output logic             busy,
  output logic             done,
  output logic             stallreq,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_p_q, neg_p_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             op_signed, op_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_next;
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ge;
  logic [PW-1:0]    div_next;
  logic [PW-1:0]    prod_fin;
  logic [WIDTH-1:0] quo_fin, rem_fin;

  assign op_signed = (op == OP_MULT) | (op == OP_DIV);
  assign op_div    = (op == OP_DIV)  | (op == OP_DIVU);
  assign mag_a = (op_signed && src_a[WIDTH-1]) ? WIDTH'(twos_neg(NEG_W'(src_a))) : src_a;
  assign mag_b = (op_signed && src_b[WIDTH-1]) ? WIDTH'(twos_neg(NEG_W'(src_b))) : src_b;

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: upper half is the remainder, lower half the dividend/quotient shifter.
  assign div_shift = acc_q[PW-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_trial[WIDTH];
  assign div_next  = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ge};

  assign prod_fin = neg_p_q ? PW'(twos_neg(NEG_W'(mul_next))) : mul_next;
  assign quo_fin  = neg_p_q ? WIDTH'(twos_neg(NEG_W'(div_next[WIDTH-1:0])))
                            : div_next[WIDTH-1:0];
  assign rem_fin  = neg_r_q ? WIDTH'(twos_neg(NEG_W'(div_next[PW-1:WIDTH])))
                            : div_next[PW-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          is_div_d = op_div;
          neg_p_d  = op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_r_d  = op_signed & src_a[WIDTH-1];
          cnt_d    = '0;
          dbz_d    = 1'b0;
          if (op_div && (src_b == '0)) begin
            hi_d    = src_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            opnd_d  = op_div ? mag_b : mag_a;
            acc_d   = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (annul) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
            if (is_div_q) begin
              hi_d = rem_fin;
              lo_d = quo_fin;
            end else begin
              hi_d = prod_fin[PW-1:WIDTH];
              lo_d = prod_fin[WIDTH-1:0];
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign stallreq    = ((state_q == S_IDLE) & start & ~annul) | (state_q == S_RUN);
  assign result_hi   = hi_q;
  assign result_lo   = lo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
